game_round_controller_mp: RTL and testbench

- Next-generation hole-in-the-wall game controller: explicit FSM, N-player elimination, countdown between rounds and per-round speed ramp.
- Sits between the per-pixel stream (hcount/vcount, person mask, wall-mask lookup) and the renderer/HUD.
- Counts per-player wall collisions each frame, advances wall depth, selects the next wall bitmask and reports game state.
- The wall bitmask lookup is external; this block drives its index and consumes its per-pixel result.

---
 rtl/glc_pkg.sv | 32 +++
 rtl/frame_collision_counter.sv | 52 +++++
 rtl/game_round_controller_mp.sv | 224 ++++++++++++++++++++++
 tb/tb_game_round_controller_mp.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/glc_pkg.sv
// Shared types and width helpers for the hole-in-the-wall round controller.
package glc_pkg;

    typedef enum logic [2:0] {
        GS_IDLE      = 3'd0,
        GS_COUNTDOWN = 3'd1,
        GS_ADVANCE   = 3'd2,
        GS_ROUND_END = 3'd3,
        GS_WON       = 3'd4,
        GS_LOST      = 3'd5
    } game_state_t;

    function automatic int COLL_CNT_W(input int width, input int height);
        return $clog2(width * height + 1);
    endfunction

    function automatic int ROUND_W(input int max_rounds);
        return $clog2(max_rounds + 1);
    endfunction

    // A single wall still needs a 1-bit index port.
    function automatic int WALL_W(input int num_walls);
        return (num_walls > 1) ? $clog2(num_walls) : 1;
    endfunction

    function automatic int MAX3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/frame_collision_counter.sv
// Per-player saturating frame hit counter with threshold judging and alive flag.
module frame_collision_counter
    import glc_pkg::*;
#(
    parameter int CNT_W     = 20,
    parameter int THRESHOLD = 65536
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_count_en,
    input  logic i_new_frame,
    input  logic i_judge_en,
    input  logic i_person_wall,
    output logic o_hit,
    output logic o_alive,
    output logic o_alive_next
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_alive;
    logic [CNT_W:0]   w_eff;
    logic             w_over;

    assign o_hit        = i_person_wall & r_alive;
    // The pixel that closes the frame still counts toward that frame's total.
    assign w_eff        = {1'b0, r_cnt} + (CNT_W + 1)'(o_hit);
    assign w_over       = (int'(w_eff) >= THRESHOLD);
    assign o_alive_next = r_alive & ~(i_judge_en & w_over);
    assign o_alive      = r_alive;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_start || i_new_frame) begin
            r_cnt <= '0;
        end else if (i_count_en && o_hit && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_alive <= 1'b0;
        end else if (i_start) begin
            r_alive <= 1'b1;
        end else begin
            r_alive <= o_alive_next;
        end
    end

endmodule

// File: rtl/game_round_controller_mp.sv
// Round FSM, wall depth/speed control and 1-cycle pixel pipeline.
// Optional macro GLC_SPEED_RAMP_EN: shorten frames-per-tick by one each round, down to the floor.
module game_round_controller_mp
    import glc_pkg::*;
#(
    parameter int SCREEN_WIDTH             = 1280,
    parameter int SCREEN_HEIGHT            = 720,
    parameter int NUM_PLAYERS              = 2,
    parameter int NUM_WALLS                = 10,
    parameter int MAX_ROUNDS               = 5,
    parameter int GOAL_DEPTH               = 60,
    parameter int GOAL_DEPTH_DELTA         = 10,
    parameter int MAX_WALL_DEPTH           = 75,
    parameter int MAX_FRAMES_PER_WALL_TICK = 15,
    parameter int MIN_FRAMES_PER_WALL_TICK = 4,
    parameter int COUNTDOWN_FRAMES         = 60,
    parameter int COLLISION_THRESHOLD      = 65536
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            start_game_in,
    input  logic [10:0]                     hcount_in,
    input  logic [9:0]                      vcount_in,
    input  logic                            data_valid_in,
    input  logic                            is_wall_in,
    input  logic [NUM_PLAYERS-1:0]          is_person_in,
    output logic [10:0]                     hcount_out,
    output logic [9:0]                      vcount_out,
    output logic                            data_valid_out,
    output logic                            is_wall_out,
    output logic [NUM_PLAYERS-1:0]          is_collision_out,
    output logic [7:0]                      wall_depth_out,
    output logic [WALL_W(NUM_WALLS)-1:0]    wall_idx_out,
    output logic [ROUND_W(MAX_ROUNDS)-1:0]  curr_round_out,
    output logic [NUM_PLAYERS-1:0]          alive_out,
    output logic [2:0]                      game_state_out
);

    localparam int CNT_W    = COLL_CNT_W(SCREEN_WIDTH, SCREEN_HEIGHT);
    localparam int RND_W    = ROUND_W(MAX_ROUNDS);
    localparam int IDX_W    = WALL_W(NUM_WALLS);
    localparam int TICK_W   = $clog2(MAX3(COUNTDOWN_FRAMES, MAX_FRAMES_PER_WALL_TICK,
                                          MIN_FRAMES_PER_WALL_TICK) + 1);
    localparam int JUDGE_LO = GOAL_DEPTH - GOAL_DEPTH_DELTA;
    localparam int JUDGE_HI = GOAL_DEPTH + GOAL_DEPTH_DELTA;

    game_state_t             r_state, w_state_next;
    logic [TICK_W-1:0]       r_tick;
    logic [TICK_W-1:0]       r_fpt;
    logic [7:0]              r_depth;
    logic [RND_W-1:0]        r_round;
    logic [IDX_W-1:0]        r_wall_idx;

    logic [10:0]             r_hcount;
    logic [9:0]              r_vcount;
    logic                    r_valid;
    logic                    r_wall;
    logic [NUM_PLAYERS-1:0]  r_collision;

    logic                    w_new_frame;
    logic                    w_idle_like;
    logic                    w_start;
    logic                    w_advance;
    logic                    w_in_window;
    logic                    w_judge;
    logic                    w_lose;
    logic                    w_cd_done;
    logic                    w_tick_done;
    logic                    w_last_depth;
    logic [RND_W-1:0]        w_round_inc;
    logic [NUM_PLAYERS-1:0]  w_hit;
    logic [NUM_PLAYERS-1:0]  w_alive;
    logic [NUM_PLAYERS-1:0]  w_alive_next;

    assign w_new_frame  = data_valid_in && (hcount_in == 11'(SCREEN_WIDTH - 1))
                                        && (vcount_in == 10'(SCREEN_HEIGHT - 1));
    assign w_idle_like  = (r_state == GS_IDLE) || (r_state == GS_WON) || (r_state == GS_LOST);
    assign w_start      = w_idle_like && start_game_in;
    assign w_advance    = (r_state == GS_ADVANCE);
    assign w_in_window  = (int'(r_depth) >= JUDGE_LO) && (int'(r_depth) <= JUDGE_HI);
    assign w_judge      = w_advance && w_new_frame && w_in_window;
    assign w_lose       = w_advance && (w_alive_next == '0);
    assign w_cd_done    = w_new_frame && (r_tick == TICK_W'(COUNTDOWN_FRAMES - 1));
    assign w_tick_done  = w_new_frame && (r_tick == (r_fpt - TICK_W'(1)));
    assign w_last_depth = (r_depth == 8'(MAX_WALL_DEPTH - 1));
    assign w_round_inc  = r_round + RND_W'(1);

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
        frame_collision_counter #(
            .CNT_W     (CNT_W),
            .THRESHOLD (COLLISION_THRESHOLD)
        ) u_counter (
            .i_clk         (clk_in),
            .i_rst_n       (rst_n_in),
            .i_start       (w_start),
            .i_count_en    (w_advance),
            .i_new_frame   (w_new_frame),
            .i_judge_en    (w_judge),
            .i_person_wall (data_valid_in & is_wall_in & is_person_in[g]),
            .o_hit         (w_hit[g]),
            .o_alive       (w_alive[g]),
            .o_alive_next  (w_alive_next[g])
        );
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= GS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Elimination of the last player outranks any tick or round completion.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            GS_IDLE, GS_WON, GS_LOST: begin
                if (start_game_in) w_state_next = GS_COUNTDOWN;
            end
            GS_COUNTDOWN: begin
                if (w_cd_done) w_state_next = GS_ADVANCE;
            end
            GS_ADVANCE: begin
                if (w_lose) begin
                    w_state_next = GS_LOST;
                end else if (w_tick_done && w_last_depth) begin
                    w_state_next = GS_ROUND_END;
                end
            end
            GS_ROUND_END: begin
                w_state_next = (w_round_inc == RND_W'(MAX_ROUNDS)) ? GS_WON : GS_COUNTDOWN;
            end
            default: w_state_next = GS_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tick     <= '0;
            r_fpt      <= TICK_W'(MAX_FRAMES_PER_WALL_TICK);
            r_depth    <= '0;
            r_round    <= '0;
            r_wall_idx <= '0;
        end else begin
            case (r_state)
                GS_IDLE, GS_WON, GS_LOST: begin
                    if (start_game_in) begin
                        r_tick     <= '0;
                        r_fpt      <= TICK_W'(MAX_FRAMES_PER_WALL_TICK);
                        r_depth    <= '0;
                        r_round    <= '0;
                        r_wall_idx <= '0;
                    end
                end
                GS_COUNTDOWN: begin
                    if (w_cd_done) begin
                        r_tick <= '0;
                    end else if (w_new_frame) begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end
                GS_ADVANCE: begin
                    if (w_new_frame && !w_lose) begin
                        if (w_tick_done) begin
                            r_tick <= '0;
                            if (!w_last_depth) r_depth <= r_depth + 8'd1;
                        end else begin
                            r_tick <= r_tick + TICK_W'(1);
                        end
                    end
                end
                GS_ROUND_END: begin
                    r_tick  <= '0;
                    r_depth <= '0;
                    r_round <= w_round_inc;
                    if (r_wall_idx == IDX_W'(NUM_WALLS - 1)) begin
                        r_wall_idx <= '0;
                    end else begin
                        r_wall_idx <= r_wall_idx + IDX_W'(1);
                    end
`ifdef GLC_SPEED_RAMP_EN
                    if (r_fpt > TICK_W'(MIN_FRAMES_PER_WALL_TICK)) begin
                        r_fpt <= r_fpt - TICK_W'(1);
                    end else begin
                        r_fpt <= TICK_W'(MIN_FRAMES_PER_WALL_TICK);
                    end
`else
                    r_fpt <= TICK_W'(MAX_FRAMES_PER_WALL_TICK);
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_hcount    <= '0;
            r_vcount    <= '0;
            r_valid     <= 1'b0;
            r_wall      <= 1'b0;
            r_collision <= '0;
        end else begin
            r_hcount    <= hcount_in;
            r_vcount    <= vcount_in;
            r_valid     <= data_valid_in;
            r_wall      <= is_wall_in & data_valid_in;
            r_collision <= w_hit;
        end
    end

    assign hcount_out       = r_hcount;
    assign vcount_out       = r_vcount;
    assign data_valid_out   = r_valid;
    assign is_wall_out      = r_wall;
    assign is_collision_out = r_collision;
    assign wall_depth_out   = r_depth;
    assign wall_idx_out     = r_wall_idx;
    assign curr_round_out   = r_round;
    assign alive_out        = w_alive;
    assign game_state_out   = r_state;

endmodule

// File: tb/tb_game_round_controller_mp.sv
// Directed self-checking bench: 8x4 screen, 2 players, 2 walls, 3 rounds, goal 4+/-1, threshold 4.
module tb_game_round_controller_mp;
    import glc_pkg::*;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int NW  = 2;
    localparam int MR  = 3;
`ifdef GLC_SPEED_RAMP_EN
    localparam int FPT_LATE = 2;
`else
    localparam int FPT_LATE = 3;
`endif

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        start_game_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        data_valid_in;
    logic        is_wall_in;
    logic [1:0]  is_person_in;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        data_valid_out;
    logic        is_wall_out;
    logic [1:0]  is_collision_out;
    logic [7:0]  wall_depth_out;
    logic [WALL_W(NW)-1:0] wall_idx_out;
    logic [ROUND_W(MR)-1:0] curr_round_out;
    logic [1:0]  alive_out;
    logic [2:0]  game_state_out;

    int checkCount = 0;
    int errorCount = 0;

    game_round_controller_mp #(
        .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .NUM_PLAYERS(2), .NUM_WALLS(NW),
        .MAX_ROUNDS(MR), .GOAL_DEPTH(4), .GOAL_DEPTH_DELTA(1), .MAX_WALL_DEPTH(6),
        .MAX_FRAMES_PER_WALL_TICK(3), .MIN_FRAMES_PER_WALL_TICK(2),
        .COUNTDOWN_FRAMES(2), .COLLISION_THRESHOLD(4)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_game_in(start_game_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .data_valid_in(data_valid_in),
        .is_wall_in(is_wall_in), .is_person_in(is_person_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out), .data_valid_out(data_valid_out),
        .is_wall_out(is_wall_out), .is_collision_out(is_collision_out),
        .wall_depth_out(wall_depth_out), .wall_idx_out(wall_idx_out),
        .curr_round_out(curr_round_out), .alive_out(alive_out),
        .game_state_out(game_state_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input int h, input int v,
                                 input logic wall, input logic [1:0] person);
        data_valid_in = valid;
        hcount_in     = 11'(h);
        vcount_in     = 10'(v);
        is_wall_in    = wall;
        is_person_in  = person;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 0, 0, 1'b0, 2'b00);
    endtask

    // n0/n1 wall hits for each player, then the frame-closing pixel carrying lastP.
    task automatic sendFrame(input int n0, input int n1, input logic [1:0] lastP);
        int n;
        n = (n0 > n1) ? n0 : n1;
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b1, 0, 0, 1'b1, {1'(k < n1), 1'(k < n0)});
        end
        applyStimulus(1'b1, W - 1, H - 1, |lastP, lastP);
        data_valid_in = 1'b0;
        is_wall_in    = 1'b0;
        is_person_in  = 2'b00;
    endtask

    task automatic runFrames(input int count);
        for (int f = 0; f < count; f++) sendFrame(0, 0, 2'b00);
    endtask

    task automatic pulseStart();
        start_game_in = 1'b1;
        idleCycle();
        start_game_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n_in = 1'b0;
        start_game_in = 1'b0;
        data_valid_in = 1'b0;
        hcount_in = '0;
        vcount_in = '0;
        is_wall_in = 1'b0;
        is_person_in = '0;
        repeat (3) @(posedge clk_in);
        #1;
        checkOutput("rst_state", int'(game_state_out), 0);
        checkOutput("rst_alive", int'(alive_out), 0);
        rst_n_in = 1'b1;

        // Pipeline latency, wall gating by valid, no hits while nobody is alive
        applyStimulus(1'b1, 5, 2, 1'b1, 2'b11);
        checkOutput("pipe_hcount", int'(hcount_out), 5);
        checkOutput("pipe_vcount", int'(vcount_out), 2);
        checkOutput("pipe_valid", int'(data_valid_out), 1);
        checkOutput("pipe_wall", int'(is_wall_out), 1);
        checkOutput("pipe_coll_dead", int'(is_collision_out), 0);
        applyStimulus(1'b0, 6, 1, 1'b1, 2'b00);
        checkOutput("pipe_wall_invalid", int'(is_wall_out), 0);
        checkOutput("pipe_hcount2", int'(hcount_out), 6);

        // Reset in the middle of ADVANCE
        pulseStart();
        runFrames(2);
        runFrames(3);
        checkOutput("pre_rst_state", int'(game_state_out), 2);
        checkOutput("pre_rst_depth", int'(wall_depth_out), 1);
        rst_n_in = 1'b0;
        #2;
        checkOutput("mid_rst_state", int'(game_state_out), 0);
        checkOutput("mid_rst_depth", int'(wall_depth_out), 0);
        checkOutput("mid_rst_alive", int'(alive_out), 0);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        idleCycle();
        checkOutput("post_rst_state", int'(game_state_out), 0);

        // Game A: start and countdown
        pulseStart();
        checkOutput("a_start_state", int'(game_state_out), 1);
        checkOutput("a_start_alive", int'(alive_out), 3);
        checkOutput("a_start_round", int'(curr_round_out), 0);
        runFrames(1);
        checkOutput("a_cd1_state", int'(game_state_out), 1);
        runFrames(1);
        checkOutput("a_cd2_state", int'(game_state_out), 2);

        // Round 0 ticks every 3 frames; start ignored during ADVANCE
        runFrames(2);
        checkOutput("a_r0_f2_depth", int'(wall_depth_out), 0);
        start_game_in = 1'b1;
        runFrames(1);
        start_game_in = 1'b0;
        checkOutput("a_r0_f3_depth", int'(wall_depth_out), 1);
        checkOutput("a_start_ignored", int'(game_state_out), 2);

        // Threshold reached outside the judging window
        sendFrame(4, 0, 2'b00);
        checkOutput("a_depth1_alive", int'(alive_out), 3);
        runFrames(2);
        checkOutput("a_depth2", int'(wall_depth_out), 2);
        runFrames(3);
        checkOutput("a_depth3", int'(wall_depth_out), 3);

        // At depth 3: P0 reaches 4 on the closing pixel, P1 stops at 3
        applyStimulus(1'b1, 1, 1, 1'b1, 2'b11);
        checkOutput("a_coll_both", int'(is_collision_out), 3);
        sendFrame(2, 2, 2'b01);
        checkOutput("a_coll_last", int'(is_collision_out), 1);
        checkOutput("a_elim_p0", int'(alive_out), 2);
        applyStimulus(1'b1, 1, 1, 1'b1, 2'b11);
        checkOutput("a_coll_dead_p0", int'(is_collision_out), 2);
        runFrames(2);
        checkOutput("a_depth4", int'(wall_depth_out), 4);
        runFrames(3);
        runFrames(2);
        checkOutput("a_depth5", int'(wall_depth_out), 5);
        checkOutput("a_depth5_state", int'(game_state_out), 2);
        runFrames(1);
        checkOutput("a_rend_state", int'(game_state_out), 3);
        checkOutput("a_rend_depth", int'(wall_depth_out), 5);
        idleCycle();
        checkOutput("a_r1_state", int'(game_state_out), 1);
        checkOutput("a_r1_round", int'(curr_round_out), 1);
        checkOutput("a_r1_wall", int'(wall_idx_out), 1);
        checkOutput("a_r1_depth", int'(wall_depth_out), 0);
        checkOutput("a_r1_alive", int'(alive_out), 2);

        // Round 1 speed depends on the ramp option
        runFrames(2);
        checkOutput("a_r1_adv", int'(game_state_out), 2);
        runFrames(2);
        checkOutput("a_r1_f2_depth", int'(wall_depth_out), (FPT_LATE == 2) ? 1 : 0);
        runFrames(1);
        checkOutput("a_r1_f3_depth", int'(wall_depth_out), 1);
        runFrames(6 * FPT_LATE - 3);
        checkOutput("a_r1_rend", int'(game_state_out), 3);
        idleCycle();
        checkOutput("a_r2_round", int'(curr_round_out), 2);
        checkOutput("a_r2_wall_wrap", int'(wall_idx_out), 0);

        // Round 2 completes the game
        runFrames(2);
        runFrames(6 * FPT_LATE - 1);
        checkOutput("a_r2_pre_end", int'(game_state_out), 2);
        runFrames(1);
        checkOutput("a_r2_rend", int'(game_state_out), 3);
        idleCycle();
        checkOutput("a_won_state", int'(game_state_out), 4);
        checkOutput("a_won_round", int'(curr_round_out), 3);
        checkOutput("a_won_wall", int'(wall_idx_out), 1);
        runFrames(3);
        checkOutput("a_won_hold", int'(game_state_out), 4);
        checkOutput("a_won_hold_alive", int'(alive_out), 2);

        // Game B: restart from WON, both players eliminated on the final tick
        pulseStart();
        checkOutput("b_start_state", int'(game_state_out), 1);
        checkOutput("b_start_alive", int'(alive_out), 3);
        checkOutput("b_start_round", int'(curr_round_out), 0);
        checkOutput("b_start_wall", int'(wall_idx_out), 0);
        runFrames(2);
        runFrames(2);
        checkOutput("b_f2_depth", int'(wall_depth_out), 0);
        runFrames(1);
        checkOutput("b_f3_depth", int'(wall_depth_out), 1);
        runFrames(14);
        checkOutput("b_depth5", int'(wall_depth_out), 5);
        sendFrame(4, 4, 2'b00);
        checkOutput("b_lost_state", int'(game_state_out), 5);
        checkOutput("b_lost_alive", int'(alive_out), 0);
        idleCycle();
        checkOutput("b_lost_hold", int'(game_state_out), 5);
        checkOutput("b_lost_depth", int'(wall_depth_out), 5);
        applyStimulus(1'b1, 3, 1, 1'b0, 2'b00);
        checkOutput("b_lost_pipe", int'(hcount_out), 3);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
